// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator / frame checker pair.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Output buffer handshake between the frame checker and its consumer.
interface parity_frame_checker_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] out_data;
  logic              out_par_err;
  logic              out_frm_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data, out_par_err, out_frm_err, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_par_err, out_frm_err, out_valid,
    output out_ready
  );
endinterface

// File: rtl/parity_calc.sv
// XOR-reduce parity with odd/even select; the generator uses the same equation.
module parity_calc #(
  parameter int DATA_W = 4,
  parameter bit ODD    = 1'b0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  assign par_o = (^data_i) ^ ODD;

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start, DATA_W bits MSB-first, parity, stop; one-entry output buffer.
module parity_frame_checker
  import parity_pkg::state_e, parity_pkg::IDLE, parity_pkg::DATA,
         parity_pkg::PARITY, parity_pkg::STOP, parity_pkg::DEFAULT_DATA_W,
         parity_pkg::PARITY_EVEN;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter bit PARITY_ODD = PARITY_EVEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bit_en,
  input  logic                    serial_in,
  parity_frame_checker_if.master  out_if,
  output logic                    overrun,
  output logic                    busy
);

  localparam int                CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                prx_q, prx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                commit;
  logic                par_exp;

  parity_calc #(
    .DATA_W (DATA_W),
    .ODD    (PARITY_ODD)
  ) u_parity_calc (
    .data_i (shift_q),
    .par_o  (par_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      prx_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      prx_q   <= prx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // The stop value never blocks the return to IDLE; it only sets the framing flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    prx_d   = prx_q;
    commit  = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!serial_in) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = DATA_W'({shift_q, serial_in});
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          prx_d   = serial_in;
          state_d = STOP;
        end
        STOP: begin
          commit  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit may reuse the buffer in the same cycle the consumer drains it.
  always_comb begin
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (commit) begin
      if (!valid_q || out_if.out_ready) begin
        data_d  = shift_q;
        perr_d  = prx_q ^ par_exp;
        ferr_d  = ~serial_in;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out_if.out_data    = data_q;
  assign out_if.out_par_err = perr_q;
  assign out_if.out_frm_err = ferr_q;
  assign out_if.out_valid   = valid_q;
  assign overrun            = ovr_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: even and odd instances share one serial stream.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bitEn = 1'b0;
  logic serialIn = 1'b1;
  logic ready = 1'b0;

  int checks = 0;
  int errors = 0;

  parity_frame_checker_if #(.DATA_W(4)) ifEven ();
  parity_frame_checker_if #(.DATA_W(4)) ifOdd ();

  logic overrunE, busyE, overrunO, busyO;

  assign ifEven.out_ready = ready;
  assign ifOdd.out_ready  = ready;

  parity_frame_checker #(.DATA_W(4), .PARITY_ODD(1'b0)) dutEven (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bitEn),
    .serial_in (serialIn),
    .out_if    (ifEven),
    .overrun   (overrunE),
    .busy      (busyE)
  );

  parity_frame_checker #(.DATA_W(4), .PARITY_ODD(1'b1)) dutOdd (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_en    (bitEn),
    .serial_in (serialIn),
    .out_if    (ifOdd),
    .overrun   (overrunO),
    .busy      (busyO)
  );

  always #5 clk = ~clk;

  logic [3:0] dData [2];
  logic       dPerr [2];
  logic       dFerr [2];
  logic       dValid[2];
  logic       dOver [2];
  logic       dBusy [2];

  assign dData[0] = ifEven.out_data;     assign dData[1] = ifOdd.out_data;
  assign dPerr[0] = ifEven.out_par_err;  assign dPerr[1] = ifOdd.out_par_err;
  assign dFerr[0] = ifEven.out_frm_err;  assign dFerr[1] = ifOdd.out_frm_err;
  assign dValid[0] = ifEven.out_valid;   assign dValid[1] = ifOdd.out_valid;
  assign dOver[0] = overrunE;            assign dOver[1] = overrunO;
  assign dBusy[0] = busyE;               assign dBusy[1] = busyO;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect sampled line bits into a frame, decode once seven bits are in.
  logic       bitsQ[$];
  logic [3:0] mData [2];
  logic       mPerr [2];
  logic       mFerr [2];
  logic       mValid[2];
  logic       mOver [2];

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] frameData;
    logic       committed;
    if (!rst_n) begin
      bitsQ.delete();
      for (int k = 0; k < 2; k++) begin
        mData[k] = '0; mPerr[k] = 1'b0; mFerr[k] = 1'b0;
        mValid[k] = 1'b0; mOver[k] = 1'b0;
      end
    end else begin
      committed = 1'b0;
      if (bitEn) begin
        if (bitsQ.size() != 0 || serialIn == 1'b0) bitsQ.push_back(serialIn);
        if (bitsQ.size() == 7) begin
          frameData = {bitsQ[1], bitsQ[2], bitsQ[3], bitsQ[4]};
          for (int k = 0; k < 2; k++) begin
            if (!mValid[k] || ready) begin
              mData[k]  = frameData;
              mPerr[k]  = bitsQ[5] ^ ($countones(frameData) % 2 == 1) ^ (k == 1);
              mFerr[k]  = ~bitsQ[6];
              mValid[k] = 1'b1;
            end else begin
              mOver[k] = 1'b1;
            end
          end
          bitsQ.delete();
          committed = 1'b1;
        end
      end
      if (!committed)
        for (int k = 0; k < 2; k++)
          if (mValid[k] && ready) mValid[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("model valid[%0d]", k), 8'(dValid[k]), 8'(mValid[k]));
      checkOutput($sformatf("model overrun[%0d]", k), 8'(dOver[k]), 8'(mOver[k]));
      checkOutput($sformatf("model busy[%0d]", k), 8'(dBusy[k]), 8'(bitsQ.size() != 0));
      if (mValid[k]) begin
        checkOutput($sformatf("model data[%0d]", k), 8'(dData[k]), 8'(mData[k]));
        checkOutput($sformatf("model par_err[%0d]", k), 8'(dPerr[k]), 8'(mPerr[k]));
        checkOutput($sformatf("model frm_err[%0d]", k), 8'(dFerr[k]), 8'(mFerr[k]));
      end
    end
  end

  // Drive one serial bit after `gap` idle cycles; entered and left on a falling edge.
  task automatic applyStimulus(input logic b, input int gap, input logic readyWithBit);
    repeat (gap) @(negedge clk);
    serialIn = b;
    bitEn = 1'b1;
    if (readyWithBit) ready = 1'b1;
    @(negedge clk);
    bitEn = 1'b0;
    serialIn = 1'b1;
  endtask

  task automatic sendFrame(input logic [3:0] d, input logic p, input logic stopBit,
                           input int gapSeed, input logic readyOnStop);
    logic [6:0] bits;
    bits = {1'b0, d, p, stopBit};
    for (int i = 6; i >= 0; i--)
      applyStimulus(bits[i], (gapSeed < 0) ? 1 : ((6 - i) * 3 + gapSeed) % 8,
                    (i == 0) && readyOnStop);
  endtask

  task automatic pulseReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset valid", 8'(ifEven.out_valid), 8'd0);
    checkOutput("reset data", 8'(ifEven.out_data), 8'd0);
    checkOutput("reset overrun", 8'(overrunE), 8'd0);
    checkOutput("reset busy", 8'(busyE), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("por valid", 8'(ifEven.out_valid), 8'd0);
    checkOutput("por busy", 8'(busyE), 8'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1011, P=1: even parity good, odd instance sees a parity error.
    sendFrame(4'b1011, 1'b1, 1'b1, -1, 1'b0);
    checkOutput("t1 valid", 8'(ifEven.out_valid), 8'd1);
    checkOutput("t1 data", 8'(ifEven.out_data), 8'hB);
    checkOutput("t1 par_err even", 8'(ifEven.out_par_err), 8'd0);
    checkOutput("t1 frm_err", 8'(ifEven.out_frm_err), 8'd0);
    checkOutput("t1 par_err odd", 8'(ifOdd.out_par_err), 8'd1);
    @(negedge clk);
    checkOutput("t1 consumed", 8'(ifEven.out_valid), 8'd0);

    sendFrame(4'b1011, 1'b0, 1'b1, -1, 1'b0);
    checkOutput("t2 data", 8'(ifEven.out_data), 8'hB);
    checkOutput("t2 par_err even", 8'(ifEven.out_par_err), 8'd1);
    checkOutput("t2 par_err odd", 8'(ifOdd.out_par_err), 8'd0);

    sendFrame(4'b0000, 1'b0, 1'b0, -1, 1'b0);
    checkOutput("t3 frm_err", 8'(ifEven.out_frm_err), 8'd1);
    checkOutput("t3 par_err", 8'(ifEven.out_par_err), 8'd0);
    checkOutput("t3 busy", 8'(busyE), 8'd0);
    repeat (2) @(negedge clk);

    ready = 1'b0;
    sendFrame(4'b0001, 1'b1, 1'b1, -1, 1'b0);
    checkOutput("t4 first held", 8'(ifEven.out_data), 8'h1);
    sendFrame(4'b1110, 1'b1, 1'b1, -1, 1'b0);
    checkOutput("t4 overrun", 8'(overrunE), 8'd1);
    checkOutput("t4 data kept", 8'(ifEven.out_data), 8'h1);
    checkOutput("t4 valid held", 8'(ifEven.out_valid), 8'd1);
    ready = 1'b1;
    @(negedge clk);
    checkOutput("t4 valid drop", 8'(ifEven.out_valid), 8'd0);
    checkOutput("t4 overrun sticky", 8'(overrunE), 8'd1);
    pulseReset();

    ready = 1'b0;
    sendFrame(4'b0011, 1'b0, 1'b1, -1, 1'b0);
    sendFrame(4'b0101, 1'b0, 1'b1, -1, 1'b1);
    checkOutput("t5 valid", 8'(ifEven.out_valid), 8'd1);
    checkOutput("t5 data", 8'(ifEven.out_data), 8'h5);
    checkOutput("t5 overrun", 8'(overrunE), 8'd0);
    @(negedge clk);

    // Partial frame then asynchronous reset, followed by a full frame with irregular gaps.
    applyStimulus(1'b0, 2, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 5, 1'b0);
    checkOutput("t6 busy before reset", 8'(busyE), 8'd1);
    pulseReset();
    sendFrame(4'b0110, 1'b0, 1'b1, 0, 1'b0);
    checkOutput("t6 data", 8'(ifEven.out_data), 8'h6);
    checkOutput("t6 par_err even", 8'(ifEven.out_par_err), 8'd0);
    checkOutput("t6 par_err odd", 8'(ifOdd.out_par_err), 8'd1);
    checkOutput("t6 overrun", 8'(overrunE), 8'd0);

    sendFrame(4'b1001, 1'b0, 1'b1, 4, 1'b0);
    checkOutput("t6 second data", 8'(ifEven.out_data), 8'h9);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
